crc32_stream_engine: RTL and testbench

CRC32_STREAM_ENGINE -- requirements
Module: crc32_stream_engine

---
 rtl/crc32_stream_engine.sv | 146 ++++++++++++++
 tb/tb_crc32_stream_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine: streaming IEEE 802.3 CRC32 generator/checker.
// One beat of DATA_W bits is folded per accepted cycle; the eop beat folds
// only its first in_bytes bytes. The result is registered, and it is held
// until the consumer takes it.
//
// state  | meaning
// IDLE   | waiting for a sop beat; non-sop beats are dropped
// IN_PKT | packet open, the running CRC is in crc_q
module crc32_stream_engine #(
    parameter int          DATA_W = 32,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sop,
    input  logic                          in_eop,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [$clog2(DATA_W/8):0]     in_bytes,
    input  logic                          mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_crc,
    output logic                          out_ok,
    output logic                          proto_err
);

    localparam int          BYTES   = DATA_W / 8;
    localparam int          CW      = $clog2(BYTES) + 1;
    localparam logic [CW-1:0] BYTES_C = CW'(BYTES);
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic        mode_q, mode_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_crc_q, out_crc_d;
    logic        out_ok_q, out_ok_d;
    logic        proto_err_q, proto_err_d;

    logic          accept;
    logic          bytes_bad;
    logic [CW-1:0] fold_bytes;
    logic [31:0]   fold_base;
    logic [31:0]   fold_crc;
    logic          pkt_mode;

    // Reflected CRC32, byte 0 first, each byte LSB first; bytes at or above
    // nbytes are left out of the fold.
    function automatic logic [31:0] crc_fold(input logic [31:0]     crc_in,
                                             input logic [DATA_W-1:0] data,
                                             input logic [CW-1:0]     nbytes);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int k = 0; k < BYTES; k++) begin
            if (CW'(k) < nbytes) begin
                for (int b = 0; b < 8; b++) begin
                    fb = c[0] ^ data[8*k+b];
                    c  = {1'b0, c[31:1]} ^ (fb ? POLY : 32'h0);
                end
            end
        end
        return c;
    endfunction

    assign in_ready  = !(out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign bytes_bad = in_eop && ((in_bytes == '0) || (in_bytes > BYTES_C));

    assign out_valid = out_valid_q;
    assign out_crc   = out_crc_q;
    assign out_ok    = out_ok_q;
    assign proto_err = proto_err_q;

    // Fold of the current beat: a sop beat always restarts from INIT.
    always_comb begin
        fold_base  = in_sop ? INIT : crc_q;
        fold_bytes = (in_eop && !bytes_bad) ? in_bytes : BYTES_C;
        fold_crc   = crc_fold(fold_base, in_data, fold_bytes);
        pkt_mode   = in_sop ? mode : mode_q;
    end

    // Next-state, running CRC and result register updates.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_crc_d   = out_crc_q;
        out_ok_d    = out_ok_q;
        proto_err_d = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (!in_sop && (state_q == IDLE)) begin
                proto_err_d = 1'b1;
            end else begin
                proto_err_d = bytes_bad || (in_sop && (state_q == IN_PKT));
                mode_d      = pkt_mode;
                if (in_eop) begin
                    state_d     = IDLE;
                    crc_d       = INIT;
                    out_valid_d = 1'b1;
                    out_crc_d   = ~fold_crc;
                    out_ok_d    = pkt_mode && (fold_crc == RESIDUE);
                end else begin
                    state_d = IN_PKT;
                    crc_d   = fold_crc;
                end
            end
        end
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_crc_q   <= 32'h0;
            out_ok_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_crc_q   <= out_crc_d;
            out_ok_q    <= out_ok_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Bench for crc32_stream_engine: directed golden vectors on a 32-bit engine,
// then random packets on 32/64/128-bit engines against a byte-queue model.
module tb_crc32_stream_engine;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_sop;
    logic         in_eop;
    logic [127:0] in_data;
    logic [4:0]   in_bytes;
    logic         mode;
    logic         out_ready;
    int           sel;

    logic [2:0]   vld_w, ordy_w, rdy_w, ov_w, ok_w, pe_w;
    logic [31:0]  crc_w [3];

    logic         cur_rdy, cur_ov, cur_ok, cur_pe;
    logic [31:0]  cur_crc;

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_sel
        assign vld_w[g]  = in_valid && (sel == g);
        assign ordy_w[g] = out_ready && (sel == g);
    end

    assign cur_rdy = rdy_w[sel];
    assign cur_ov  = ov_w[sel];
    assign cur_ok  = ok_w[sel];
    assign cur_pe  = pe_w[sel];
    assign cur_crc = crc_w[sel];

    crc32_stream_engine #(.DATA_W(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(vld_w[0]), .in_ready(rdy_w[0]),
        .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data[31:0]), .in_bytes(in_bytes[2:0]),
        .mode(mode), .out_valid(ov_w[0]), .out_ready(ordy_w[0]), .out_crc(crc_w[0]),
        .out_ok(ok_w[0]), .proto_err(pe_w[0]));

    crc32_stream_engine #(.DATA_W(64)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(vld_w[1]), .in_ready(rdy_w[1]),
        .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data[63:0]), .in_bytes(in_bytes[3:0]),
        .mode(mode), .out_valid(ov_w[1]), .out_ready(ordy_w[1]), .out_crc(crc_w[1]),
        .out_ok(ok_w[1]), .proto_err(pe_w[1]));

    crc32_stream_engine #(.DATA_W(128)) u_dut128 (
        .clk(clk), .reset_n(reset_n), .in_valid(vld_w[2]), .in_ready(rdy_w[2]),
        .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .in_bytes(in_bytes),
        .mode(mode), .out_valid(ov_w[2]), .out_ready(ordy_w[2]), .out_crc(crc_w[2]),
        .out_ok(ok_w[2]), .proto_err(pe_w[2]));

    typedef struct packed {
        logic [31:0] crc;
        logic        ok;
    } res_t;

    int           n_checks = 0;
    int           n_err    = 0;
    res_t         exp_q[$];
    logic [31:0]  got_q[$];
    logic         got_ok_last;
    int           perr_exp, perr_obs;
    byte unsigned pkt_bytes[$];
    bit           m_in_pkt, m_mode;
    bit           rnd_ready;
    bit           rdy_seen;
    bit           hold_pend;
    logic [31:0]  hold_crc;
    logic         hold_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Plain bit-serial IEEE 802.3 CRC over a byte list.
    function automatic logic [31:0] ref_crc(input byte unsigned q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c ^= {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] word_crc(input logic [31:0] w);
        byte unsigned q[$];
        for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
        return ref_crc(q);
    endfunction

    // Packet-level model applied to each beat the engine accepted.
    task automatic model_accept(input bit sop, input bit eop, input logic [127:0] d,
                                input int nb, input bit m);
        int          bytes;
        int          n;
        bit          perr;
        logic [31:0] c;
        bytes = 4 << sel;
        perr  = 0;
        if (!sop && !m_in_pkt) begin
            perr_exp++;
            return;
        end
        if (sop) begin
            if (m_in_pkt) perr = 1;
            pkt_bytes.delete();
            m_mode   = m;
            m_in_pkt = 1;
        end
        n = bytes;
        if (eop) begin
            if (nb == 0 || nb > bytes) perr = 1;
            else n = nb;
        end
        for (int i = 0; i < n; i++) pkt_bytes.push_back(d[8*i +: 8]);
        if (eop) begin
            c = ref_crc(pkt_bytes);
            exp_q.push_back({c, m_mode && (c == 32'h2144DF1C)});
            m_in_pkt = 0;
        end
        if (perr) perr_exp++;
    endtask

    task automatic monitor();
        res_t r;
        if (!reset_n) begin
            hold_pend = 0;
            return;
        end
        if (hold_pend) begin
            check("hold_valid", cur_ov, 1);
            check("hold_crc", cur_crc, hold_crc);
            check("hold_ok", cur_ok, hold_ok);
        end
        hold_pend = cur_ov && !out_ready;
        hold_crc  = cur_crc;
        hold_ok   = cur_ok;
        if (cur_pe) perr_obs++;
        if (cur_ov && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                r = exp_q.pop_front();
                check("result_crc", cur_crc, r.crc);
                check("result_ok", cur_ok, r.ok);
            end
            got_q.push_back(cur_crc);
            got_ok_last = cur_ok;
        end
    endtask

    // One clock: observe at the falling edge, then move to just after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        rdy_seen = cur_rdy;
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input bit sop, input bit eop, input logic [127:0] d,
                             input int nb, input bit m);
        bit acc;
        in_valid = 1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        in_bytes = 5'(nb);
        mode     = m;
        acc      = 0;
        for (int i = 0; i < 300 && !acc; i++) begin
            step();
            acc = rdy_seen;
        end
        if (!acc) check("accept_timeout", 0, 1);
        else model_accept(sop, eop, d, nb, m);
        in_valid = 0;
        in_sop   = 0;
        in_eop   = 0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        bit done;
        rnd_ready = 0;
        out_ready = 1;
        done      = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (!cur_ov && exp_q.size() == 0) done = 1;
        end
        if (!done) check("drain_timeout", 0, 1);
        check("proto_err_count", perr_obs, perr_exp);
    endtask

    task automatic do_reset();
        reset_n = 0;
        step();
        step();
        reset_n  = 1;
        m_in_pkt = 0;
    endtask

    initial begin
        reset_n   = 0;
        in_valid  = 0;
        in_sop    = 0;
        in_eop    = 0;
        in_data   = '0;
        in_bytes  = '0;
        mode      = 0;
        out_ready = 0;
        sel       = 0;
        rnd_ready = 0;
        perr_exp  = 0;
        perr_obs  = 0;
        m_in_pkt  = 0;
        m_mode    = 0;
        hold_pend = 0;

        step();
        step();
        check("reset_out_valid", cur_ov, 0);
        check("reset_out_crc", cur_crc, 32'h0);
        check("reset_out_ok", cur_ok, 0);
        check("reset_proto_err", cur_pe, 0);
        check("reset_in_ready", cur_rdy, 1);
        reset_n = 1;
        step();

        // Golden single beat and one-cycle latency.
        got_q.delete();
        out_ready = 1;
        send_beat(1, 1, 128'h12345678, 4, 0);
        check("latency_valid", cur_ov, 1);
        check("golden_crc_direct", cur_crc, 32'hAF6D87D2);
        check("golden_ok_direct", cur_ok, 0);
        drain();
        check("golden_count", got_q.size(), 1);
        check("golden_crc", got_q[0], 32'hAF6D87D2);

        // "123456789" with a one-byte last beat.
        got_q.delete();
        send_beat(1, 0, 128'h34333231, 4, 0);
        send_beat(0, 0, 128'h38373635, 4, 0);
        send_beat(0, 1, 128'hAABBCC39, 1, 0);
        drain();
        check("ascii_count", got_q.size(), 1);
        check("ascii_crc", got_q[0], 32'hCBF43926);

        // Check mode, good then corrupted FCS.
        got_q.delete();
        send_beat(1, 0, 128'h12345678, 4, 1);
        send_beat(0, 1, 128'hAF6D87D2, 4, 0);
        drain();
        check("check_good_ok", got_ok_last, 1);
        check("check_good_crc", got_q[0], 32'h2144DF1C);
        send_beat(1, 0, 128'h12345678, 4, 1);
        send_beat(0, 1, 128'hAF6D87D3, 4, 1);
        drain();
        check("check_bad_ok", got_ok_last, 0);

        // Backpressure with a second packet waiting on the held result.
        got_q.delete();
        out_ready = 0;
        send_beat(1, 1, 128'h12345678, 4, 0);
        in_valid = 1;
        in_sop   = 1;
        in_eop   = 1;
        in_data  = 128'hDEADBEEF;
        in_bytes = 5'd4;
        mode     = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_in_ready", rdy_seen, 0);
            check("bp_hold_crc", cur_crc, 32'hAF6D87D2);
        end
        out_ready = 1;
        step();
        check("bp_release_ready", rdy_seen, 1);
        if (rdy_seen) model_accept(1, 1, 128'hDEADBEEF, 4, 0);
        in_valid = 0;
        in_sop   = 0;
        in_eop   = 0;
        check("bp_same_edge_valid", cur_ov, 1);
        drain();
        check("bp_count", got_q.size(), 2);
        check("bp_first", got_q[0], 32'hAF6D87D2);
        check("bp_second", got_q[1], word_crc(32'hDEADBEEF));

        // Protocol errors: stray beat, sop mid-packet, bad in_bytes.
        got_q.delete();
        send_beat(0, 1, 128'h11111111, 4, 0);
        drain();
        check("stray_no_result", got_q.size(), 0);
        send_beat(1, 0, 128'hAAAAAAAA, 4, 0);
        send_beat(0, 0, 128'h55555555, 4, 0);
        send_beat(1, 1, 128'h12345678, 4, 0);
        drain();
        check("restart_count", got_q.size(), 1);
        check("restart_crc", got_q[0], 32'hAF6D87D2);
        got_q.delete();
        send_beat(1, 1, 128'h12345678, 0, 0);
        drain();
        check("bytes0_crc", got_q[0], 32'hAF6D87D2);

        // Reset in the middle of a packet.
        got_q.delete();
        send_beat(1, 0, 128'hCAFEF00D, 4, 0);
        send_beat(0, 0, 128'h01020304, 4, 0);
        do_reset();
        send_beat(1, 1, 128'h12345678, 4, 0);
        drain();
        check("reset_mid_count", got_q.size(), 1);
        check("reset_mid_crc", got_q[0], 32'hAF6D87D2);

        // Random packets on each width with random out_ready.
        for (int s = 0; s < 3; s++) begin
            int bytes;
            sel       = s;
            bytes     = 4 << s;
            rnd_ready = 1;
            got_q.delete();
            for (int p = 0; p < 50; p++) begin
                int nbeats;
                bit pm;
                nbeats = $urandom_range(1, 4);
                pm     = 1'($urandom_range(0, 1));
                for (int b = 0; b < nbeats; b++) begin
                    int nb;
                    nb = bytes;
                    if (b == nbeats - 1) begin
                        if ($urandom_range(0, 7) == 0) nb = $urandom_range(0, 2 * bytes - 1);
                        else nb = $urandom_range(1, bytes);
                    end
                    for (int g = $urandom_range(0, 2); g > 0; g--) step();
                    send_beat(b == 0, b == nbeats - 1,
                              {$urandom, $urandom, $urandom, $urandom}, nb, pm);
                end
            end
            drain();
            check("random_count", got_q.size(), 50);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
